alu_op_sequencer: RTL and testbench

//  Initiator side of the ALU control interface. It accepts one decoded 6502-class
//    ALU operation at a time and drives the ALU's one-hot enables, operands and carry-in.
//  It captures the ALU's combinational result, updates the N/Z/C/V flags and emits a

---
 rtl/alu_op_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU control interface: issues one ALU op, captures the result and flags,
// and runs the read-modify-write sequence with the 2A03 dummy write of the original value.
module alu_op_sequencer #(
    parameter int DW  = 8,
    parameter int OPW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          op_valid_i,
    output logic          op_ready_o,
    input  logic [OPW-1:0] op_code_i,
    input  logic          op_rmw_i,
    input  logic [DW-1:0] a_in_i,
    input  logic [DW-1:0] m_in_i,
    input  logic          c_in_i,
    input  logic          v_in_i,
    output logic          sum_en_o,
    output logic          and_en_o,
    output logic          eor_en_o,
    output logic          or_en_o,
    output logic          sr_en_o,
    output logic          inv_en_o,
    output logic          ror_en_o,
    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    output logic          alu_cin_o,
    input  logic [DW-1:0] alu_res_i,
    input  logic          alu_cout_i,
    output logic [DW-1:0] res_o,
    output logic          n_out_o,
    output logic          z_out_o,
    output logic          c_out_o,
    output logic          v_out_o,
    output logic          done_o,
    output logic          reg_we_o,
    output logic          mem_we_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          illegal_o
);

    // state | meaning
    // IDLE  | op_ready high, waiting for a request
    // ISSUE | ALU enables/operands driven, result settling
    // CAPT  | result and flags captured; done here for non-RMW ops
    // DUMMY | RMW: write original memory value back
    // WRITE | RMW: write result to memory, done
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CAPT  = 3'd2,
        DUMMY = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam logic [OPW-1:0] OP_ADC = OPW'(0);
    localparam logic [OPW-1:0] OP_SBC = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_ORA = OPW'(3);
    localparam logic [OPW-1:0] OP_EOR = OPW'(4);
    localparam logic [OPW-1:0] OP_CMP = OPW'(5);
    localparam logic [OPW-1:0] OP_LSR = OPW'(6);
    localparam logic [OPW-1:0] OP_ROR = OPW'(7);
    localparam logic [OPW-1:0] OP_ASL = OPW'(8);
    localparam logic [OPW-1:0] OP_ROL = OPW'(9);
    localparam logic [OPW-1:0] OP_INC = OPW'(10);
    localparam logic [OPW-1:0] OP_DEC = OPW'(11);

    // enable vector bit order: sum, and, eor, or, sr, inv, ror
    localparam logic [6:0] EN_SUM = 7'b1000000;
    localparam logic [6:0] EN_AND = 7'b0100000;
    localparam logic [6:0] EN_EOR = 7'b0010000;
    localparam logic [6:0] EN_OR  = 7'b0001000;
    localparam logic [6:0] EN_SR  = 7'b0000100;
    localparam logic [6:0] EN_INV = 7'b0000010;
    localparam logic [6:0] EN_ROR = 7'b0000001;

    state_t          state_q;
    logic            ready_q;
    logic [OPW-1:0]  op_q;
    logic            rmw_q;
    logic [DW-1:0]   m_q;
    logic            c_q;
    logic            v_q;
    logic [6:0]      en_q;
    logic [DW-1:0]   alu_a_q;
    logic [DW-1:0]   alu_b_q;
    logic            alu_cin_q;
    logic [DW-1:0]   res_q;
    logic            n_q, z_q, c_flag_q, v_flag_q;
    logic            done_q, reg_we_q, mem_we_q, illegal_q;
    logic [DW-1:0]   mem_wdata_q;

    logic [6:0]      issue_en_d;
    logic [DW-1:0]   issue_a_d;
    logic [DW-1:0]   issue_b_d;
    logic            issue_cin_d;
    logic            illegal_d;
    logic [DW-1:0]   opnd;

    logic            beff_msb;
    logic            v_calc;
    logic            c_flag_d;
    logic            v_flag_d;

    assign opnd      = op_rmw_i ? m_in_i : a_in_i;
    assign illegal_d = (op_code_i > OP_DEC) || (op_rmw_i && (op_code_i < OP_LSR));

    always_comb begin
        issue_en_d  = '0;
        issue_a_d   = '0;
        issue_b_d   = '0;
        issue_cin_d = 1'b0;
        unique case (op_code_i)
            OP_ADC: begin issue_en_d = EN_SUM;          issue_a_d = a_in_i; issue_b_d = m_in_i; issue_cin_d = c_in_i; end
            OP_SBC: begin issue_en_d = EN_SUM | EN_INV; issue_a_d = a_in_i; issue_b_d = m_in_i; issue_cin_d = c_in_i; end
            OP_AND: begin issue_en_d = EN_AND;          issue_a_d = a_in_i; issue_b_d = m_in_i; end
            OP_ORA: begin issue_en_d = EN_OR;           issue_a_d = a_in_i; issue_b_d = m_in_i; end
            OP_EOR: begin issue_en_d = EN_EOR;          issue_a_d = a_in_i; issue_b_d = m_in_i; end
            OP_CMP: begin issue_en_d = EN_SUM | EN_INV; issue_a_d = a_in_i; issue_b_d = m_in_i; issue_cin_d = 1'b1; end
            OP_LSR: begin issue_en_d = EN_SR;           issue_a_d = opnd; end
            OP_ROR: begin issue_en_d = EN_ROR;          issue_a_d = opnd; issue_cin_d = c_in_i; end
            OP_ASL: begin issue_en_d = EN_SUM;          issue_a_d = opnd; issue_b_d = opnd; end
            OP_ROL: begin issue_en_d = EN_SUM;          issue_a_d = opnd; issue_b_d = opnd; issue_cin_d = c_in_i; end
            OP_INC: begin issue_en_d = EN_SUM;          issue_a_d = opnd; issue_cin_d = 1'b1; end
            OP_DEC: begin issue_en_d = EN_SUM | EN_INV; issue_a_d = opnd; end
            default: ;
        endcase
    end

    // Overflow is derived here from the issued operands rather than trusted from the ALU.
    assign beff_msb = en_q[1] ? ~alu_b_q[DW-1] : alu_b_q[DW-1];
    assign v_calc   = (alu_a_q[DW-1] == beff_msb) && (alu_res_i[DW-1] != alu_a_q[DW-1]);

    always_comb begin
        c_flag_d = c_q;
        v_flag_d = v_q;
        case (op_q)
            OP_ADC, OP_SBC: begin c_flag_d = alu_cout_i; v_flag_d = v_calc; end
            OP_CMP, OP_LSR, OP_ROR, OP_ASL, OP_ROL: c_flag_d = alu_cout_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            op_q        <= '0;
            rmw_q       <= 1'b0;
            m_q         <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            en_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_cin_q   <= 1'b0;
            res_q       <= '0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_flag_q    <= 1'b0;
            v_flag_q    <= 1'b0;
            done_q      <= 1'b0;
            reg_we_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            reg_we_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            illegal_q <= 1'b0;
            en_q      <= '0;
            case (state_q)
                IDLE: begin
                    if (op_valid_i && ready_q) begin
                        if (illegal_d) begin
                            illegal_q <= 1'b1;
                        end else begin
                            op_q      <= op_code_i;
                            rmw_q     <= op_rmw_i;
                            m_q       <= m_in_i;
                            c_q       <= c_in_i;
                            v_q       <= v_in_i;
                            en_q      <= issue_en_d;
                            alu_a_q   <= issue_a_d;
                            alu_b_q   <= issue_b_d;
                            alu_cin_q <= issue_cin_d;
                            ready_q   <= 1'b0;
                            state_q   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    res_q    <= alu_res_i;
                    n_q      <= alu_res_i[DW-1];
                    z_q      <= (alu_res_i == '0);
                    c_flag_q <= c_flag_d;
                    v_flag_q <= v_flag_d;
                    if (!rmw_q) begin
                        done_q   <= 1'b1;
                        reg_we_q <= (op_q != OP_CMP);
                    end
                    state_q <= CAPT;
                end
                CAPT: begin
                    if (rmw_q) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= m_q;
                        state_q     <= DUMMY;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                DUMMY: begin
                    mem_we_q    <= 1'b1;
                    mem_wdata_q <= res_q;
                    done_q      <= 1'b1;
                    state_q     <= WRITE;
                end
                WRITE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign op_ready_o  = ready_q;
    assign sum_en_o    = en_q[6];
    assign and_en_o    = en_q[5];
    assign eor_en_o    = en_q[4];
    assign or_en_o     = en_q[3];
    assign sr_en_o     = en_q[2];
    assign inv_en_o    = en_q[1];
    assign ror_en_o    = en_q[0];
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_cin_o   = alu_cin_q;
    assign res_o       = res_q;
    assign n_out_o     = n_q;
    assign z_out_o     = z_q;
    assign c_out_o     = c_flag_q;
    assign v_out_o     = v_flag_q;
    assign done_o      = done_q;
    assign reg_we_o    = reg_we_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: table of single ops through a behavioural ALU,
// plus hand sequences for RMW, illegal ops and reset during the dummy write.
module tb_alu_op_sequencer;

    logic       clk, rst_n;
    logic       op_valid, op_ready, op_rmw, c_in, v_in;
    logic [3:0] op_code;
    logic [7:0] a_in, m_in;
    logic       sum_en, and_en, eor_en, or_en, sr_en, inv_en, ror_en;
    logic [7:0] alu_a, alu_b, alu_res, res, mem_wdata;
    logic       alu_cin, alu_cout;
    logic       n_out, z_out, c_out, v_out, done, reg_we, mem_we, illegal;

    int nvec = 0;
    int nerr = 0;

    alu_op_sequencer #(.DW(8), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .op_valid_i(op_valid), .op_ready_o(op_ready),
        .op_code_i(op_code), .op_rmw_i(op_rmw),
        .a_in_i(a_in), .m_in_i(m_in), .c_in_i(c_in), .v_in_i(v_in),
        .sum_en_o(sum_en), .and_en_o(and_en), .eor_en_o(eor_en), .or_en_o(or_en),
        .sr_en_o(sr_en), .inv_en_o(inv_en), .ror_en_o(ror_en),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_cin_o(alu_cin),
        .alu_res_i(alu_res), .alu_cout_i(alu_cout),
        .res_o(res), .n_out_o(n_out), .z_out_o(z_out), .c_out_o(c_out), .v_out_o(v_out),
        .done_o(done), .reg_we_o(reg_we), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .illegal_o(illegal)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: inv complements B into the adder.
    always_comb begin
        logic [8:0] s;
        logic [7:0] b;
        alu_res  = 8'h00;
        alu_cout = 1'b0;
        s        = 9'h000;
        b        = inv_en ? ~alu_b : alu_b;
        if (sum_en) begin
            s        = {1'b0, alu_a} + {1'b0, b} + {8'h00, alu_cin};
            alu_res  = s[7:0];
            alu_cout = s[8];
        end else if (and_en) alu_res = alu_a & alu_b;
        else if (or_en)      alu_res = alu_a | alu_b;
        else if (eor_en)     alu_res = alu_a ^ alu_b;
        else if (sr_en) begin
            alu_res  = {1'b0, alu_a[7:1]};
            alu_cout = alu_a[0];
        end else if (ror_en) begin
            alu_res  = {alu_cin, alu_a[7:1]};
            alu_cout = alu_a[0];
        end
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, m;
        logic       c, v;
        logic [6:0] en;
        logic [7:0] res;
        logic       n, z, co, vo, we;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] a, m, input logic c, v,
                                input logic [6:0] en, input logic [7:0] r,
                                input logic n, z, co, vo, we);
        vec_t t;
        t.op = op; t.a = a; t.m = m; t.c = c; t.v = v; t.en = en;
        t.res = r; t.n = n; t.z = z; t.co = co; t.vo = vo; t.we = we;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ens();
        return {sum_en, and_en, eor_en, or_en, sr_en, inv_en, ror_en};
    endfunction

    task automatic wait_ready();
        for (int k = 0; k < 8; k++) begin
            if (op_ready) break;
            @(negedge clk);
        end
        chk("op_ready before issue", op_ready, 1);
    endtask

    task automatic issue(input logic [3:0] op, input logic rmw, input logic [7:0] a, m,
                         input logic c, v);
        wait_ready();
        op_code = op; op_rmw = rmw; a_in = a; m_in = m; c_in = c; v_in = v;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        a_in = ~a; m_in = ~m; c_in = ~c; v_in = ~v;
    endtask

    task automatic apply(input int i, input vec_t t);
        issue(t.op, 1'b0, t.a, t.m, t.c, t.v);
        @(negedge clk);
        chk($sformatf("v%0d enables", i), ens(), t.en);
        chk($sformatf("v%0d done in ISSUE", i), done, 0);
        @(negedge clk);
        chk($sformatf("v%0d done", i), done, 1);
        chk($sformatf("v%0d reg_we", i), reg_we, t.we);
        chk($sformatf("v%0d res", i), res, t.res);
        chk($sformatf("v%0d nzcv", i), {n_out, z_out, c_out, v_out}, {t.n, t.z, t.co, t.vo});
        chk($sformatf("v%0d mem_we", i), mem_we, 0);
        chk($sformatf("v%0d enables off", i), ens(), 0);
        @(negedge clk);
        chk($sformatf("v%0d done after", i), done, 0);
        chk($sformatf("v%0d ready after", i), op_ready, 1);
        chk($sformatf("v%0d res hold", i), res, t.res);
    endtask

    initial begin
        //                op     a      m      c  v  en          res    n  z  co vo we
        vecs[0]  = mk(4'd0,  8'h50, 8'h50, 0, 0, 7'b1000000, 8'hA0, 1, 0, 0, 1, 1); // ADC
        vecs[1]  = mk(4'd1,  8'h50, 8'hF0, 1, 1, 7'b1000010, 8'h60, 0, 0, 0, 0, 1); // SBC
        vecs[2]  = mk(4'd5,  8'h40, 8'h40, 0, 1, 7'b1000010, 8'h00, 0, 1, 1, 1, 0); // CMP
        vecs[3]  = mk(4'd11, 8'h00, 8'h55, 1, 0, 7'b1000010, 8'hFF, 1, 0, 1, 0, 1); // DEC
        vecs[4]  = mk(4'd10, 8'hFF, 8'h12, 0, 1, 7'b1000000, 8'h00, 0, 1, 0, 1, 1); // INC
        vecs[5]  = mk(4'd6,  8'h01, 8'h77, 0, 0, 7'b0000100, 8'h00, 0, 1, 1, 0, 1); // LSR
        vecs[6]  = mk(4'd2,  8'hF0, 8'h3C, 1, 1, 7'b0100000, 8'h30, 0, 0, 1, 1, 1); // AND
        vecs[7]  = mk(4'd3,  8'h0F, 8'h80, 0, 0, 7'b0001000, 8'h8F, 1, 0, 0, 0, 1); // ORA
        vecs[8]  = mk(4'd4,  8'hFF, 8'hFF, 1, 0, 7'b0010000, 8'h00, 0, 1, 1, 0, 1); // EOR
        vecs[9]  = mk(4'd7,  8'h01, 8'h00, 1, 0, 7'b0000001, 8'h80, 1, 0, 1, 0, 1); // ROR
        vecs[10] = mk(4'd8,  8'hC0, 8'h00, 0, 1, 7'b1000000, 8'h80, 1, 0, 1, 1, 1); // ASL
        vecs[11] = mk(4'd0,  8'hFF, 8'h01, 1, 0, 7'b1000000, 8'h01, 0, 0, 1, 0, 1); // ADC carry
        vecs[12] = mk(4'd1,  8'h80, 8'h01, 1, 0, 7'b1000010, 8'h7F, 0, 0, 1, 1, 1); // SBC overflow

        clk = 0; rst_n = 0; op_valid = 0; op_code = 0; op_rmw = 0;
        a_in = 0; m_in = 0; c_in = 0; v_in = 0;
        @(negedge clk); @(negedge clk);
        chk("reset enables", ens(), 0);
        chk("reset res/flags", {res, n_out, z_out, c_out, v_out}, 0);
        chk("reset strobes", {done, reg_we, mem_we, illegal}, 0);
        chk("reset alu operands", {alu_a, alu_b, alu_cin}, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        rst_n = 1;
        @(negedge clk);
        chk("ready after reset", op_ready, 1);

        for (int i = 0; i < 13; i++) apply(i, vecs[i]);

        // RMW ROL: dummy write of original value, then result; done only in WRITE
        issue(4'd9, 1'b1, 8'h11, 8'h80, 1'b1, 1'b0);
        @(negedge clk);
        chk("rol issue en", ens(), 7'b1000000);
        chk("rol issue ops", {alu_a, alu_b, alu_cin}, {8'h80, 8'h80, 1'b1});
        @(negedge clk);
        chk("rol capt strobes", {done, reg_we, mem_we}, 0);
        chk("rol capt res", res, 8'h01);
        @(negedge clk);
        chk("rol dummy strobes", {done, mem_we}, 2'b01);
        chk("rol dummy wdata", mem_wdata, 8'h80);
        @(negedge clk);
        chk("rol write strobes", {done, reg_we, mem_we}, 3'b101);
        chk("rol write wdata", mem_wdata, 8'h01);
        chk("rol write nzc", {n_out, z_out, c_out}, 3'b001);
        @(negedge clk);
        chk("rol idle", {done, mem_we, op_ready}, 3'b001);

        // Illegal: op_code 13, then AND with op_rmw
        issue(4'd13, 1'b0, 8'h01, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        chk("ill13 pulse", {illegal, done, op_ready}, 3'b101);
        chk("ill13 no enables", ens(), 0);
        @(negedge clk);
        chk("ill13 end", {illegal, done, op_ready}, 3'b001);
        issue(4'd2, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        chk("illand pulse", {illegal, done, op_ready}, 3'b101);
        chk("illand res held", res, 8'h01);
        @(negedge clk);
        chk("illand end", {illegal, done, mem_we, op_ready}, 4'b0001);

        // Reset asserted in DUMMY aborts with no further strobes
        issue(4'd10, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("inc dummy mem_we", {mem_we, mem_wdata}, {1'b1, 8'h10});
        #2 rst_n = 0;
        #1;
        chk("abort strobes", {done, reg_we, mem_we, illegal}, 0);
        chk("abort res/flags", {res, n_out, z_out, c_out, v_out}, 0);
        chk("abort wdata/ops", {mem_wdata, alu_a, alu_b, alu_cin}, 0);
        @(negedge clk); @(negedge clk);
        chk("abort mem_we held", mem_we, 0);
        rst_n = 1;
        @(negedge clk);
        chk("abort no late write", {mem_we, done}, 0);
        apply(100, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
